// File: rtl/demux_pkg.sv
// Shared constants and helpers for the phy_rx round-robin demux.
// Mask and clamp helpers are sized generously; callers narrow them.
package demux_pkg;

  localparam int WIDTH_DFLT = 8;
  localparam int LANES_DFLT = 4;
  localparam int MAX_LANES  = 32;

  function automatic logic [MAX_LANES-1:0] lane_mask(
    input int unsigned n
  );
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  function automatic int unsigned clamp_lanes(
    input int unsigned la,
    input int unsigned lanes
  );
    return (la == 0 || la > lanes) ? lanes : la;
  endfunction

endpackage

// File: rtl/demux_lane_ctrl.sv
// Lane index / frame length tracking for the round-robin demux.
// Emits per-lane capture enables plus full and flush strobes.
module demux_lane_ctrl
  import demux_pkg::*;
#(
  parameter  int LANES = LANES_DFLT,
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [IDX_W:0]   lanes_active,
  output logic [LANES-1:0] cap_en,
  output logic             emit_full,
  output logic             emit_flush,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W:0]   n_eff
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   n_act_q, n_act_d;
  logic [IDX_W:0]   n_clamp;
  logic [IDX_W:0]   idx_nx;
  logic             idle;

  assign idle    = (idx_q == '0);
  assign n_clamp = (IDX_W+1)'(clamp_lanes(32'(lanes_active), LANES));
  assign idx_nx  = {1'b0, idx_q} + (IDX_W+1)'(1);
  assign idx     = idx_q;

  // Frame length is taken live on the first word so n_act==1 emits at once.
  always_comb begin
    n_eff      = idle ? n_clamp : n_act_q;
    cap_en     = '0;
    emit_full  = 1'b0;
    emit_flush = 1'b0;
    idx_d      = idx_q;
    n_act_d    = n_act_q;
    if (valid_in) begin
      cap_en[idx_q] = 1'b1;
      if (idle) n_act_d = n_clamp;
      if (idx_nx == n_eff) begin
        emit_full = 1'b1;
        idx_d     = '0;
      end else begin
        idx_d = idx_nx[IDX_W-1:0];
      end
    end else if (!idle) begin
      emit_flush = 1'b1;
      idx_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      n_act_q <= (IDX_W+1)'(LANES);
    end else begin
      idx_q   <= idx_d;
      n_act_q <= n_act_d;
    end
  end

endmodule

// File: rtl/demux_1xn_rr.sv
// 1-to-N round-robin word demultiplexer with registered frame output.
// Gaps in the input flush a partially filled frame.
module demux_1xn_rr
  import demux_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DFLT,
  parameter  int LANES = LANES_DFLT,
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [IDX_W:0]         lanes_active,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic                   frame_out,
  output logic                   flush_out
);

  logic [LANES-1:0] cap_en;
  logic             emit_full;
  logic             emit_flush;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   n_eff;

  demux_lane_ctrl #(
    .LANES(LANES)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (reset_L),
    .valid_in    (valid_in),
    .lanes_active(lanes_active),
    .cap_en      (cap_en),
    .emit_full   (emit_full),
    .emit_flush  (emit_flush),
    .idx         (idx),
    .n_eff       (n_eff)
  );

  logic [WIDTH-1:0]       stage_q [LANES];
  logic [WIDTH-1:0]       stage_d [LANES];
  logic [LANES*WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]       valid_q, valid_d;
  logic                   frame_q, frame_d;
  logic                   flush_q, flush_d;
  logic [LANES-1:0]       mask_full;
  logic [LANES-1:0]       mask_fl;

  assign mask_full = LANES'(lane_mask(32'(n_eff)));
  assign mask_fl   = LANES'(lane_mask(32'(idx)));

  // The closing word is bypassed straight into its lane of the frame.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      stage_d[i] = cap_en[i] ? data_in : stage_q[i];
    end
    data_d  = data_q;
    valid_d = '0;
    frame_d = emit_full;
    flush_d = emit_flush;
    if (emit_full) begin
      valid_d = mask_full;
      for (int i = 0; i < LANES; i++) begin
        if (!mask_full[i])
          data_d[i*WIDTH +: WIDTH] = '0;
        else if (IDX_W'(i) == idx)
          data_d[i*WIDTH +: WIDTH] = data_in;
        else
          data_d[i*WIDTH +: WIDTH] = stage_q[i];
      end
    end else if (emit_flush) begin
      valid_d = mask_fl;
      for (int i = 0; i < LANES; i++) begin
        data_d[i*WIDTH +: WIDTH] = mask_fl[i] ? stage_q[i] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < LANES; i++) stage_q[i] <= '0;
      data_q  <= '0;
      valid_q <= '0;
      frame_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) stage_q[i] <= stage_d[i];
      data_q  <= data_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      flush_q <= flush_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign frame_out = frame_q;
  assign flush_out = flush_q;

endmodule

// File: tb/tb_demux_1xn_rr.sv
// Directed bench for demux_1xn_rr, LANES=4, WIDTH=8.
module tb_demux_1xn_rr;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        valid_in;
  logic [7:0]  data_in;
  logic [2:0]  lanes_active;
  logic [3:0]  valid_out;
  logic [31:0] data_out;
  logic        frame_out;
  logic        flush_out;

  int n_tests = 0;
  int n_fail  = 0;

  demux_1xn_rr #(
    .WIDTH(8),
    .LANES(4)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .lanes_active(lanes_active),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .frame_out   (frame_out),
    .flush_out   (flush_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive at a falling edge; return at the next falling edge.
  task automatic drive(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] v,
                         input logic [31:0] d, input logic fr,
                         input logic fl);
    chk({tag, ".valid"}, 64'(valid_out), 64'(v));
    chk({tag, ".data"},  64'(data_out),  64'(d));
    chk({tag, ".frame"}, 64'(frame_out), 64'(fr));
    chk({tag, ".flush"}, 64'(flush_out), 64'(fl));
  endtask

  initial begin
    reset_L      = 1'b0;
    valid_in     = 1'b0;
    data_in      = 8'h00;
    lanes_active = 3'd4;

    for (int i = 0; i < 4; i++) begin
      valid_in     = 1'($urandom_range(0, 1));
      data_in      = 8'($urandom);
      lanes_active = 3'($urandom);
      @(negedge clk);
      chk_out("rst_hold", 4'h0, 32'h0, 1'b0, 1'b0);
    end
    valid_in     = 1'b0;
    lanes_active = 3'd4;
    reset_L      = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    chk_out("rst_rel", 4'h0, 32'h0, 1'b0, 1'b0);

    // Full 4-lane frames, back to back
    drive(1'b1, 8'hFF);
    chk("f4_w1.frame", 64'(frame_out), 64'd0);
    drive(1'b1, 8'hDD);
    drive(1'b1, 8'hEE);
    chk("f4_w3.frame", 64'(frame_out), 64'd0);
    drive(1'b1, 8'hCC);
    chk_out("f4_a", 4'hF, 32'hCCEEDDFF, 1'b1, 1'b0);
    drive(1'b1, 8'hBB);
    chk_out("f4_hold", 4'h0, 32'hCCEEDDFF, 1'b0, 1'b0);
    drive(1'b1, 8'h99);
    drive(1'b1, 8'hAA);
    chk("f4_b3.frame", 64'(frame_out), 64'd0);
    drive(1'b1, 8'h88);
    chk_out("f4_b", 4'hF, 32'h88AA99BB, 1'b1, 1'b0);
    drive(1'b0, 8'h00);
    chk_out("f4_idle", 4'h0, 32'h88AA99BB, 1'b0, 1'b0);

    // Two-lane frames
    lanes_active = 3'd2;
    drive(1'b1, 8'hFF);
    chk("f2_w1.frame", 64'(frame_out), 64'd0);
    drive(1'b1, 8'hDD);
    chk_out("f2_a", 4'h3, 32'h0000DDFF, 1'b1, 1'b0);
    drive(1'b1, 8'hEE);
    chk("f2_w3.frame", 64'(frame_out), 64'd0);
    drive(1'b1, 8'hCC);
    chk_out("f2_b", 4'h3, 32'h0000CCEE, 1'b1, 1'b0);
    drive(1'b0, 8'h00);

    // Partial flush, then restart on lane 0
    lanes_active = 3'd4;
    drive(1'b1, 8'hBB);
    drive(1'b1, 8'h99);
    chk("fl_w2.flush", 64'(flush_out), 64'd0);
    drive(1'b0, 8'h00);
    chk_out("fl_a", 4'h3, 32'h000099BB, 1'b0, 1'b1);
    drive(1'b1, 8'hAA);
    chk_out("fl_gap", 4'h0, 32'h000099BB, 1'b0, 1'b0);
    drive(1'b0, 8'h00);
    chk_out("fl_b", 4'h1, 32'h000000AA, 1'b0, 1'b1);
    drive(1'b0, 8'h00);
    chk("fl_once.flush", 64'(flush_out), 64'd0);

    // lanes_active change mid-frame is deferred
    lanes_active = 3'd4;
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    lanes_active = 3'd1;
    drive(1'b1, 8'h33);
    chk("mid_w3.frame", 64'(frame_out), 64'd0);
    drive(1'b1, 8'h44);
    chk_out("mid_a", 4'hF, 32'h44332211, 1'b1, 1'b0);
    drive(1'b1, 8'h55);
    chk_out("n1_a", 4'h1, 32'h00000055, 1'b1, 1'b0);
    drive(1'b1, 8'h66);
    chk_out("n1_b", 4'h1, 32'h00000066, 1'b1, 1'b0);
    drive(1'b0, 8'h00);
    chk_out("n1_idle", 4'h0, 32'h00000066, 1'b0, 1'b0);

    // lanes_active 0 and out-of-range clamp to 4
    lanes_active = 3'd0;
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h03);
    chk("cl0_w3.frame", 64'(frame_out), 64'd0);
    drive(1'b1, 8'h04);
    chk_out("cl0", 4'hF, 32'h04030201, 1'b1, 1'b0);
    lanes_active = 3'd7;
    drive(1'b1, 8'h05);
    drive(1'b1, 8'h06);
    drive(1'b1, 8'h07);
    chk("cl7_w3.frame", 64'(frame_out), 64'd0);
    drive(1'b1, 8'h08);
    chk_out("cl7", 4'hF, 32'h08070605, 1'b1, 1'b0);
    drive(1'b0, 8'h00);

    // Async reset mid-frame discards the partial frame
    lanes_active = 3'd4;
    drive(1'b1, 8'h88);
    drive(1'b1, 8'h88);
    valid_in = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    chk_out("mrst_now", 4'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("mrst_hold", 4'h0, 32'h0, 1'b0, 1'b0);
    reset_L = 1'b1;
    drive(1'b0, 8'h00);
    chk_out("mrst_rel", 4'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 8'h77);
    drive(1'b1, 8'h77);
    drive(1'b1, 8'h77);
    chk_out("mrst_w3", 4'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 8'h77);
    chk_out("mrst_f", 4'hF, 32'h77777777, 1'b1, 1'b0);
    drive(1'b0, 8'h00);
    chk_out("mrst_end", 4'h0, 32'h77777777, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1xn_rr.md
# demux_1xn_rr

Parametrised 1-to-N round-robin byte demultiplexer for the phy_rx datapath, single clock domain. It replaces the fixed 1x4/8-bit demux and its divided-clock scheme. Consecutive valid input words are distributed to lanes 0..n-1 and emitted together as one registered frame. It adds a runtime lane count and partial-frame flush when the input stream gaps.

## Interface
Parameters:
- WIDTH, 8, bits per word/lane
- LANES, 4, number of output lanes (≥2)
- IDX_W, $clog2(LANES), localparam, lane index width

Ports:
- clk  in  1  sole clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- valid_in  in  1  data_in holds a word this cycle
- data_in  in  WIDTH  input word
- lanes_active  in  IDX_W+1  lanes used per frame; sampled only at frame start; 0 or >LANES treated as LANES
- valid_out  out  LANES  per-lane valid of the emitted frame, one-cycle pulse
- data_out  out  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
- frame_out  out  1  one-cycle pulse: full frame of n_act words emitted
- flush_out  out  1  one-cycle pulse: partial frame emitted

## Operation
- State: stage[LANES] registers, idx (0..LANES-1), n_act (latched lane count).
- idx==0 is IDLE; idx>0 is FILL.
- On an edge with valid_in=1 and idx==0: n_act <= clamp(lanes_active); the word goes to lane 0.
- On an edge with valid_in=1: stage[idx] <= data_in.
  - If idx+1 == n_act, emit full: data_out <= stage with data_in bypassed into lane idx; valid_out <= low n_act bits set; frame_out <= 1; idx <= 0.
  - Otherwise idx <= idx+1.
- n_act==1 is legal: every valid word emits immediately on lane 0.
- On an edge with valid_in=0 and idx>0, flush: data_out <= stage[0..idx-1]; valid_out <= low idx bits set; flush_out <= 1; idx <= 0.
- Lanes not valid in an emission are driven to 0 in data_out.
- data_out holds its value between emissions. valid_out, frame_out and flush_out return to 0 the cycle after a pulse.
- A change of lanes_active mid-frame is ignored until the next frame start.
- A back-to-back stream with no gaps yields a frame every n_act cycles with no dropped cycle.
- Reset (any time, including mid-frame): idx=0, n_act=LANES, stage=0, data_out=0, valid_out=0, frame_out=0, flush_out=0. A partial frame in progress is discarded, never flushed.

## Timing
- Latency: the last word of a frame is captured at edge k; data_out, valid_out and frame_out are visible after edge k, i.e. during cycle k+1.
- Flush: the first idle edge after a partial fill produces the outputs after that edge.
- frame_out and flush_out are never high in the same cycle.
- One input word is accepted per cycle. There is no backpressure; the input is always accepted.
- The reset deassertion edge is assumed synchronous to clk at the integration level. The block adds no reset synchroniser.

## Structure
- Package demux_pkg:
  - function lane_mask(n) returning LANES bits with the low n bits set.
  - function clamp_lanes(lanes_active).
  - Default WIDTH/LANES constants shared with the phy_rx integration.
- One sub-module, demux_lane_ctrl:
  - Holds idx and n_act.
  - Produces the capture enable per lane and emit_full/emit_flush strobes.
  - The top level holds the stage registers and output registers.

## Test plan
- Reset check: hold reset_L=0 with random inputs → all outputs 0; release → no pulses until valid_in.
- LANES=4, lanes_active=4, stream FF,DD,EE,CC → one cycle after CC: data_out={CC,EE,DD,FF} (lane3..0), valid_out=4'b1111, frame_out=1; continuous BB,99,AA,88 follows with the next frame exactly 4 cycles later.
- lanes_active=2, stream FF,DD,EE,CC → two frames {DD,FF} then {CC,EE}, valid_out=4'b0011, lanes 2–3 = 00.
- Partial flush: lanes_active=4, send BB,99, then valid_in=0 → flush_out=1, valid_out=4'b0011, data_out={00,00,99,BB}; idx restarts, so the next word (AA) lands on lane 0.
- Mid-frame lanes_active change: start a 4-lane frame, set lanes_active=1 after the 2nd word → the frame still completes at 4 words; the next frame emits per word on lane 0 only.
- Reset mid-frame: send 88,88, assert reset_L=0 asynchronously between edges → outputs clear immediately, no flush pulse; after release, stream 77 x4 → a single full frame of all 77.
